// File: rtl/boot_load_ctrl.sv
// Boot loader: streams a program image into IMEM through its boot port, then releases the CPU.
// Optional macro BOOT_CHECKSUM_EN adds a trailing zero-sum checksum word and an ERR state.
module boot_load_ctrl #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned RST_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W:0]   code_size_i,
    input  logic              s_valid_i,
    input  logic [31:0]       s_data_i,
    output logic              s_ready_o,
    output logic              boot_up_o,
    output logic [ADDR_W-1:0] boot_addr_o,
    output logic [31:0]       boot_datai_o,
    output logic              boot_web_o,
    output logic              cpu_rst_n_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [ADDR_W:0] DEPTH     = {1'b1, {ADDR_W{1'b0}}};
    localparam int unsigned     HW        = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HW-1:0]   HOLD_LAST = HW'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        LOAD,
        DRAIN,
        RUN
`ifdef BOOT_CHECKSUM_EN
        , ERR
`endif
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W:0]   size_q, size_d;
    logic [HW-1:0]     hold_q, hold_d;

    logic              boot_up_q, boot_up_d;
    logic [ADDR_W-1:0] boot_addr_q, boot_addr_d;
    logic [31:0]       boot_datai_q, boot_datai_d;
    logic              boot_web_q, boot_web_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              xfer;
    logic              wr;
    logic              accept_start;
    logic [ADDR_W:0]   size_clamp;

    assign xfer       = s_valid_i & s_ready_o;
    assign size_clamp = (code_size_i > DEPTH) ? DEPTH : code_size_i;

`ifdef BOOT_CHECKSUM_EN
    logic [31:0] sum_q, sum_d;
    logic        err_q, err_d;

    // One extra beat at cnt == size carries the checksum and is never written.
    assign s_ready_o    = (state_q == LOAD) && (cnt_q <= size_q);
    assign wr           = xfer && (cnt_q < size_q);
    assign err_o        = err_q;
    assign accept_start = start_i && (state_q == IDLE || state_q == RUN || state_q == ERR);
`else
    assign s_ready_o    = (state_q == LOAD) && (cnt_q < size_q);
    assign wr           = xfer;
    assign err_o        = 1'b0;
    assign accept_start = start_i && (state_q == IDLE || state_q == RUN);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            size_q       <= '0;
            hold_q       <= '0;
            boot_up_q    <= 1'b0;
            boot_addr_q  <= '0;
            boot_datai_q <= '0;
            boot_web_q   <= 1'b1;
            cpu_rst_n_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            sum_q        <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            size_q       <= size_d;
            hold_q       <= hold_d;
            boot_up_q    <= boot_up_d;
            boot_addr_q  <= boot_addr_d;
            boot_datai_q <= boot_datai_d;
            boot_web_q   <= boot_web_d;
            cpu_rst_n_q  <= cpu_rst_n_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef BOOT_CHECKSUM_EN
            sum_q        <= sum_d;
            err_q        <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        size_d  = size_q;
        hold_d  = hold_q;
`ifdef BOOT_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        if (accept_start) begin
            state_d = HOLD;
            cnt_d   = '0;
            hold_d  = '0;
            size_d  = size_clamp;
`ifdef BOOT_CHECKSUM_EN
            sum_d   = '0;
`endif
        end else begin
            case (state_q)
                HOLD: begin
                    if (hold_q == HOLD_LAST) begin
`ifdef BOOT_CHECKSUM_EN
                        state_d = LOAD;
`else
                        state_d = (size_q == '0) ? DRAIN : LOAD;
`endif
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        cnt_d = cnt_q + 1'b1;
`ifdef BOOT_CHECKSUM_EN
                        sum_d = sum_q + s_data_i;
                        if (cnt_q == size_q) begin
                            state_d = (sum_d == '0) ? DRAIN : ERR;
                        end
`else
                        if (cnt_d == size_q) begin
                            state_d = DRAIN;
                        end
`endif
                    end
                end
                DRAIN:   state_d = RUN;
                default: ;
            endcase
        end
    end

    // Outputs are decoded from the next state so the registered copies line up with state_q.
    always_comb begin
        boot_up_d    = 1'b0;
        boot_addr_d  = boot_addr_q;
        boot_datai_d = boot_datai_q;
        boot_web_d   = 1'b1;
        cpu_rst_n_d  = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
`ifdef BOOT_CHECKSUM_EN
        err_d        = 1'b0;
`endif
        case (state_d)
            HOLD, LOAD, DRAIN: begin
                boot_up_d = 1'b1;
                busy_d    = 1'b1;
                if (wr) begin
                    boot_web_d   = 1'b0;
                    boot_addr_d  = cnt_q[ADDR_W-1:0];
                    boot_datai_d = s_data_i;
                end
            end
            RUN: begin
                boot_addr_d  = '0;
                boot_datai_d = '0;
                cpu_rst_n_d  = 1'b1;
                done_d       = 1'b1;
            end
`ifdef BOOT_CHECKSUM_EN
            ERR: begin
                boot_addr_d  = '0;
                boot_datai_d = '0;
                err_d        = 1'b1;
            end
`endif
            default: begin
                boot_addr_d  = '0;
                boot_datai_d = '0;
            end
        endcase
    end

    assign boot_up_o    = boot_up_q;
    assign boot_addr_o  = boot_addr_q;
    assign boot_datai_o = boot_datai_q;
    assign boot_web_o   = boot_web_q;
    assign cpu_rst_n_o  = cpu_rst_n_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule
